// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared widths, typedefs and helpers for the AXI-lite master engine
//
// Purpose: default widths and limits, address/data/id typedefs, the
// completion record layout, and a counter-width helper.
// Ports: none (package).
package axi_lite_pkg;

  localparam int AXI_ADDR_W     = 32;
  localparam int AXI_DATA_W     = 32;
  localparam int AXI_ID_W       = 2;
  localparam int AXI_MAX_RD_OUT = 4;
  localparam int AXI_MAX_WR_OUT = 4;

  typedef logic [AXI_ADDR_W-1:0] addr_t;
  typedef logic [AXI_DATA_W-1:0] data_t;
  typedef logic [AXI_ID_W-1:0]   id_t;

  // Completion record for the default configuration.
  typedef struct packed {
    logic  write;
    id_t   id;
    data_t data;
  } cpl_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// rtl/axi_id_fifo.sv - small synchronous FIFO holding write-ID tags
//
// Purpose: remembers the ID of every accepted write so the untagged B
// response can be reported with the ID of the oldest write in flight.
// Ports:
//   clk, rst            clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write one entry (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   head_data           current head entry
//   full, empty         occupancy flags
module axi_id_fifo
  import axi_lite_pkg::*;
#(
  parameter int WIDTH = AXI_ID_W,
  parameter int DEPTH = AXI_MAX_WR_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_master_engine.sv
// rtl/axi_lite_master_engine.sv - AXI-lite master turning a command stream into AR/AW/W traffic
//
// Purpose: accepts read/write commands, issues them on AXI-lite, tracks
// outstanding reads and writes, and merges R and B responses into one
// single-entry tagged completion stream.
// Optional: define AXI_LITE_MASTER_RID_CHECK_EN to add per-ID outstanding
// read counters; an R whose rid has nothing outstanding is then dropped.
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_data/cmd_id   command stream
//   araddr/arid/arvalid/arready              read address channel
//   awaddr/awvalid/awready                   write address channel
//   wdata/wvalid/wready                      write data channel
//   rdata/rid/rvalid/rready                  read data channel
//   bvalid/bready                            write response channel (no ID)
//   cpl_valid/cpl_ready/cpl_write/cpl_id/cpl_data  completion stream
//   err_unexpected                           sticky unexpected-response flag
module axi_lite_master_engine
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W     = AXI_ADDR_W,
  parameter int DATA_W     = AXI_DATA_W,
  parameter int ID_W       = AXI_ID_W,
  parameter int MAX_RD_OUT = AXI_MAX_RD_OUT,
  parameter int MAX_WR_OUT = AXI_MAX_WR_OUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [ID_W-1:0]   cmd_id,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  input  logic              rvalid,
  output logic              rready,
  input  logic              bvalid,
  output logic              bready,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic              cpl_write,
  output logic [ID_W-1:0]   cpl_id,
  output logic [DATA_W-1:0] cpl_data,
  output logic              err_unexpected
);

  localparam int RCW = cnt_w(MAX_RD_OUT);
  localparam int WCW = cnt_w(MAX_WR_OUT);

  logic [RCW-1:0]  rd_cnt;
  logic [WCW-1:0]  wr_cnt;
  logic [ID_W-1:0] wid_head;
  logic            wid_full;
  logic            wid_empty;

  logic acc_rd, acc_wr;
  logic ar_hs, aw_hs, w_hs;
  logic cpl_free;
  logic r_hs, b_hs;
  logic rid_ok;
  logic r_ok, r_bad;
  logic b_ok, b_bad;

  // cmd_ready looks only at registered state, so a new command is taken
  // only once the previous one has fully left the address/data channels.
  assign cmd_ready = ~arvalid & ~awvalid & ~wvalid &
                     (rd_cnt < RCW'(MAX_RD_OUT)) &
                     (wr_cnt < WCW'(MAX_WR_OUT)) & ~wid_full;

  assign acc_rd = cmd_valid & cmd_ready & ~cmd_write;
  assign acc_wr = cmd_valid & cmd_ready &  cmd_write;
  assign ar_hs  = arvalid & arready;
  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;

  // R wins over B whenever both are pending.
  assign cpl_free = ~cpl_valid | cpl_ready;
  assign rready   = cpl_free;
  assign bready   = cpl_free & ~rvalid;
  assign r_hs     = rvalid & rready;
  assign b_hs     = bvalid & bready;

`ifdef AXI_LITE_MASTER_RID_CHECK_EN
  localparam int N_IDS = 2 ** ID_W;

  logic [RCW-1:0]   id_cnt [N_IDS];
  logic [N_IDS-1:0] id_inc;
  logic [N_IDS-1:0] id_dec;

  assign rid_ok = (id_cnt[rid] != '0);
  assign id_inc = ar_hs ? (N_IDS'(1) << arid) : '0;
  assign id_dec = r_ok  ? (N_IDS'(1) << rid)  : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IDS; i++) begin
      if (rst) begin
        id_cnt[i] <= '0;
      end else begin
        case ({id_inc[i], id_dec[i]})
          2'b10:   id_cnt[i] <= id_cnt[i] + RCW'(1);
          2'b01:   id_cnt[i] <= id_cnt[i] - RCW'(1);
          default: id_cnt[i] <= id_cnt[i];
        endcase
      end
    end
  end
`else
  assign rid_ok = 1'b1;
`endif

  // Unexpected responses are still consumed so the slave cannot stall.
  assign r_ok  = r_hs & (rd_cnt != '0) & rid_ok;
  assign r_bad = r_hs & ~r_ok;
  assign b_ok  = b_hs & (wr_cnt != '0) & ~wid_empty;
  assign b_bad = b_hs & ~b_ok;

  axi_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_WR_OUT)
  ) u_wid_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (acc_wr),
    .push_data (cmd_id),
    .pop       (b_ok),
    .head_data (wid_head),
    .full      (wid_full),
    .empty     (wid_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid        <= 1'b0;
      araddr         <= '0;
      arid           <= '0;
      awvalid        <= 1'b0;
      awaddr         <= '0;
      wvalid         <= 1'b0;
      wdata          <= '0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
      cpl_valid      <= 1'b0;
      cpl_write      <= 1'b0;
      cpl_id         <= '0;
      cpl_data       <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (acc_rd) begin
        arvalid <= 1'b1;
        araddr  <= cmd_addr;
        arid    <= cmd_id;
      end else if (ar_hs) begin
        arvalid <= 1'b0;
      end

      // AW and W retire independently, in either order.
      if (acc_wr) begin
        awvalid <= 1'b1;
        awaddr  <= cmd_addr;
      end else if (aw_hs) begin
        awvalid <= 1'b0;
      end

      if (acc_wr) begin
        wvalid <= 1'b1;
        wdata  <= cmd_data;
      end else if (w_hs) begin
        wvalid <= 1'b0;
      end

      case ({acc_rd, r_ok})
        2'b10:   rd_cnt <= rd_cnt + RCW'(1);
        2'b01:   rd_cnt <= rd_cnt - RCW'(1);
        default: rd_cnt <= rd_cnt;
      endcase

      case ({acc_wr, b_ok})
        2'b10:   wr_cnt <= wr_cnt + WCW'(1);
        2'b01:   wr_cnt <= wr_cnt - WCW'(1);
        default: wr_cnt <= wr_cnt;
      endcase

      if (r_ok) begin
        cpl_valid <= 1'b1;
        cpl_write <= 1'b0;
        cpl_id    <= rid;
        cpl_data  <= rdata;
      end else if (b_ok) begin
        cpl_valid <= 1'b1;
        cpl_write <= 1'b1;
        cpl_id    <= wid_head;
        cpl_data  <= '0;
      end else if (cpl_ready) begin
        cpl_valid <= 1'b0;
      end

      if (r_bad | b_bad) begin
        err_unexpected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// tb/tb_axi_lite_master_engine.sv - self-checking bench for axi_lite_master_engine
module tb_axi_lite_master_engine;
  import axi_lite_pkg::*;

  localparam int MR = 4;
  localparam int MW = 4;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  always #5 clk = ~clk;

  logic  cmd_valid = 0, cmd_write = 0;
  addr_t cmd_addr = '0;
  data_t cmd_data = '0;
  id_t   cmd_id = '0;
  logic  cmd_ready;
  addr_t araddr, awaddr;
  id_t   arid;
  logic  arvalid, awvalid, wvalid;
  logic  arready = 0, awready = 0, wready = 0;
  data_t wdata;
  data_t rdata = '0;
  id_t   rid = '0;
  logic  rvalid = 0, bvalid = 0;
  logic  rready, bready;
  logic  cpl_valid, cpl_write;
  logic  cpl_ready = 0;
  id_t   cpl_id;
  data_t cpl_data;
  logic  err_unexpected;

  axi_lite_master_engine #(
    .ADDR_W(32), .DATA_W(32), .ID_W(2), .MAX_RD_OUT(MR), .MAX_WR_OUT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_id(cmd_id),
    .araddr(araddr), .arid(arid), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rid(rid), .rvalid(rvalid), .rready(rready),
    .bvalid(bvalid), .bready(bready),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_write(cpl_write),
    .cpl_id(cpl_id), .cpl_data(cpl_data), .err_unexpected(err_unexpected)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Transaction-level model: pending channel beats, outstanding totals,
  // per-ID read counts, write-ID queue and the single completion slot.
  bit    m_ar_v = 0, m_aw_v = 0, m_w_v = 0;
  addr_t m_araddr = '0, m_awaddr = '0;
  data_t m_wdata = '0;
  id_t   m_arid = '0;
  int    rd_out = 0, wr_out = 0;
  int    id_out [4] = '{0, 0, 0, 0};
  id_t   wid_q [$];
  bit    m_cpl_v = 0;
  cpl_t  m_cpl = '0;
  bit    m_err = 0;
  bit    started = 0;

  logic [34:0] got [$];
  int aw_cnt = 0, w_cnt = 0;

  always @(negedge clk) begin : model_b
    bit rdy, free, mb, acc, rhs, bhs, rok, bok;
    rdy  = !m_ar_v && !m_aw_v && !m_w_v && rd_out < MR && wr_out < MW;
    free = !m_cpl_v || cpl_ready;
    mb   = free && !rvalid;
    if (started) begin
      chk("cmd_ready", cmd_ready, rdy);
      chk("arvalid", arvalid, m_ar_v);
      chk("araddr", araddr, m_araddr);
      chk("arid", arid, m_arid);
      chk("awvalid", awvalid, m_aw_v);
      chk("awaddr", awaddr, m_awaddr);
      chk("wvalid", wvalid, m_w_v);
      chk("wdata", wdata, m_wdata);
      chk("rready", rready, free);
      chk("bready", bready, mb);
      chk("cpl_valid", cpl_valid, m_cpl_v);
      if (m_cpl_v) chk("cpl_fields", {cpl_write, cpl_id, cpl_data}, m_cpl);
      chk("err_unexpected", err_unexpected, m_err);
    end
    if (cpl_valid && cpl_ready) got.push_back({cpl_write, cpl_id, cpl_data});
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready) w_cnt++;

    if (rst) begin
      m_ar_v = 0; m_aw_v = 0; m_w_v = 0;
      m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_arid = '0;
      rd_out = 0; wr_out = 0;
      for (int i = 0; i < 4; i++) id_out[i] = 0;
      wid_q.delete();
      m_cpl_v = 0; m_cpl = '0; m_err = 0;
      started = 1;
    end else begin
      acc = cmd_valid && rdy;
      rhs = rvalid && free;
      bhs = bvalid && mb;
      rok = rhs && rd_out > 0;
`ifdef AXI_LITE_MASTER_RID_CHECK_EN
      rok = rok && id_out[rid] > 0;
`endif
      bok = bhs && wr_out > 0;
      if (m_ar_v && arready) id_out[m_arid]++;
      if (rok) id_out[rid]--;
      if (acc && !cmd_write) begin
        m_ar_v = 1; m_araddr = cmd_addr; m_arid = cmd_id; rd_out++;
      end else if (m_ar_v && arready) m_ar_v = 0;
      if (acc && cmd_write) begin
        m_aw_v = 1; m_w_v = 1; m_awaddr = cmd_addr; m_wdata = cmd_data;
        wr_out++; wid_q.push_back(cmd_id);
      end else begin
        if (m_aw_v && awready) m_aw_v = 0;
        if (m_w_v && wready) m_w_v = 0;
      end
      if ((rhs && !rok) || (bhs && !bok)) m_err = 1;
      if (m_cpl_v && cpl_ready) m_cpl_v = 0;
      if (rok) begin
        rd_out--;
        m_cpl_v = 1; m_cpl.write = 1'b0; m_cpl.id = rid; m_cpl.data = rdata;
      end else if (bok) begin
        wr_out--;
        m_cpl_v = 1; m_cpl.write = 1'b1; m_cpl.id = wid_q.pop_front(); m_cpl.data = '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w, input addr_t a, input data_t d, input id_t id);
    int t = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_id = id;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin n_chk++; $display("FAIL cmd_timeout: cmd_ready 0 required 1"); end
    @(posedge clk); #1 cmd_valid = 0;
  endtask

  task automatic send_r(input id_t id, input data_t d);
    int t = 0;
    rvalid = 1; rid = id; rdata = d;
    @(negedge clk);
    while (!rready && t < 50) begin @(negedge clk); t++; end
    if (!rready) begin n_chk++; $display("FAIL r_timeout: rready 0 required 1"); end
    @(posedge clk); #1 rvalid = 0;
  endtask

  task automatic send_b();
    int t = 0;
    bvalid = 1;
    @(negedge clk);
    while (!bready && t < 50) begin @(negedge clk); t++; end
    if (!bready) begin n_chk++; $display("FAIL b_timeout: bready 0 required 1"); end
    @(posedge clk); #1 bvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cpl_ready = 1;
    tick(3);
    rst = 0;
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_arvalid", arvalid, 1'b0);
    chk("reset_cpl_valid", cpl_valid, 1'b0);
    chk("reset_err", err_unexpected, 1'b0);
    chk("reset_araddr", araddr, 32'h0);

    // Single read
    arready = 1; got.delete();
    send_cmd(0, 32'h10, 0, 2'd1);
    tick(3);
    send_r(2'd1, 32'hA5A5_0001);
    tick(2);
    chk("single_cnt", got.size(), 1);
    chk("single_cpl", got[0], {1'b0, 2'd1, 32'hA5A5_0001});
    chk("single_ready", cmd_ready, 1'b1);

    // Out-of-order read return
    got.delete();
    for (int i = 0; i < 4; i++) send_cmd(0, 32'h100 + 32'(i * 4), 0, id_t'(i));
    tick(1);
    send_r(2'd3, 32'hD000_0003);
    send_r(2'd1, 32'hD000_0001);
    send_r(2'd0, 32'hD000_0000);
    send_r(2'd2, 32'hD000_0002);
    tick(2);
    chk("ooo_cnt", got.size(), 4);
    chk("ooo_0", got[0], {1'b0, 2'd3, 32'hD000_0003});
    chk("ooo_1", got[1], {1'b0, 2'd1, 32'hD000_0001});
    chk("ooo_2", got[2], {1'b0, 2'd0, 32'hD000_0000});
    chk("ooo_3", got[3], {1'b0, 2'd2, 32'hD000_0002});
    chk("ooo_err", err_unexpected, 1'b0);

    // Outstanding read limit
    got.delete();
    for (int i = 0; i < 4; i++) send_cmd(0, 32'h200 + 32'(i), 0, id_t'(i));
    tick(2);
    chk("limit_full", cmd_ready, 1'b0);
    tick(2);
    chk("limit_still_full", cmd_ready, 1'b0);
    send_r(2'd0, 32'h0000_00E0);
    chk("limit_reopen", cmd_ready, 1'b1);
    send_cmd(0, 32'h210, 0, 2'd0);
    tick(1);
    send_r(2'd1, 32'h0000_00E1);
    send_r(2'd2, 32'h0000_00E2);
    send_r(2'd3, 32'h0000_00E3);
    send_r(2'd0, 32'h0000_00E4);
    tick(2);
    chk("limit_cnt", got.size(), 5);

    // Split write: W four cycles before AW
    got.delete(); aw_cnt = 0; w_cnt = 0;
    awready = 0; wready = 1;
    send_cmd(1, 32'h20, 32'hDEAD_BEEF, 2'd2);
    tick(4);
    awready = 1;
    tick(2);
    chk("split_aw_hs", aw_cnt, 1);
    chk("split_w_hs", w_cnt, 1);
    send_b();
    tick(1);
    chk("split_cpl", got[0], {1'b1, 2'd2, 32'h0});

    // Simultaneous R and B
    send_cmd(0, 32'h30, 0, 2'd1);
    send_cmd(1, 32'h34, 32'h1234, 2'd3);
    tick(2);
    got.delete();
    rvalid = 1; rid = 2'd1; rdata = 32'hCAFE_0001; bvalid = 1;
    @(negedge clk);
    chk("sim_rready", rready, 1'b1);
    chk("sim_bready", bready, 1'b0);
    @(posedge clk); #1 rvalid = 0;
    @(negedge clk);
    chk("sim_bready2", bready, 1'b1);
    chk("sim_first_kind", cpl_write, 1'b0);
    @(posedge clk); #1 bvalid = 0;
    @(negedge clk);
    chk("sim_second", {cpl_valid, cpl_write, cpl_id}, {1'b1, 1'b1, 2'd3});
    tick(1);
    chk("sim_cnt", got.size(), 2);
    chk("sim_cpl0", got[0], {1'b0, 2'd1, 32'hCAFE_0001});
    chk("sim_cpl1", got[1], {1'b1, 2'd3, 32'h0});

    // Completion backpressure
    cpl_ready = 0;
    send_cmd(0, 32'h40, 0, 2'd2);
    send_cmd(0, 32'h44, 0, 2'd0);
    tick(2);
    send_r(2'd2, 32'h77);
    rvalid = 1; rid = 2'd0; rdata = 32'h88;
    tick(3);
    @(negedge clk);
    chk("bp_rready", rready, 1'b0);
    chk("bp_hold", {cpl_valid, cpl_data}, {1'b1, 32'h77});
    @(posedge clk); #1;
    got.delete(); cpl_ready = 1;
    send_r(2'd0, 32'h88);
    tick(2);
    chk("bp_cnt", got.size(), 2);
    chk("bp_cpl0", got[0], {1'b0, 2'd2, 32'h77});
    chk("bp_cpl1", got[1], {1'b0, 2'd0, 32'h88});

    // Unexpected B
    got.delete();
    bvalid = 1;
    tick(1);
    bvalid = 0;
    tick(3);
    chk("errb_flag", err_unexpected, 1'b1);
    chk("errb_nocpl", cpl_valid, 1'b0);
    chk("errb_cnt", got.size(), 0);

    // Mid-operation reset
    arready = 0;
    send_cmd(0, 32'h50, 0, 2'd1);
    tick(1);
    rst = 1;
    tick(1);
    rst = 0;
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_err", err_unexpected, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    arready = 1;
    tick(1);

    // Unexpected R
    got.delete();
`ifdef AXI_LITE_MASTER_RID_CHECK_EN
    send_cmd(0, 32'h60, 0, 2'd0);
    tick(2);
`endif
    send_r(2'd3, 32'h5555_0003);
    tick(2);
    chk("errr_flag", err_unexpected, 1'b1);
    chk("errr_cnt", got.size(), 0);
`ifdef AXI_LITE_MASTER_RID_CHECK_EN
    send_r(2'd0, 32'h5555_0000);
    tick(2);
    chk("errr_good", got[0], {1'b0, 2'd0, 32'h5555_0000});
`endif

    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_engine.md
Name: axi_lite_master_engine

Overview:
Synthesizable, parametrised AXI-lite master engine that turns a valid/ready command stream into pipelined AR/AW/W traffic. It tracks outstanding reads and writes up to configurable limits and accepts read data out of order by ID. R and B responses are merged into one tagged completion stream. It sits between a DUT-side command source (sequencer, DMA, CPU model) and any AXI-lite slave.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 2, read ID width; N_IDS = 2**ID_W
MAX_RD_OUT, 4, maximum outstanding reads (AR accepted, R not yet received)
MAX_WR_OUT, 4, maximum outstanding writes (command accepted, B not yet received)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  address
cmd_data  in  DATA_W  write data
cmd_id  in  ID_W  transaction ID (reads drive arid; writes tag completion)
araddr/arid/arvalid/arready  out/out/out/in  ADDR_W/ID_W/1/1  read address channel
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
wdata/wvalid/wready  out/out/in  DATA_W/1/1  write data channel
rdata/rid/rvalid/rready  in/in/in/out  DATA_W/ID_W/1/1  read data channel
bvalid/bready  in/out  1/1  write response (no ID)
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion consumer ready
cpl_write  out  1  completion kind
cpl_id  out  ID_W  completion ID
cpl_data  out  DATA_W  read data (0 for writes)
err_unexpected  out  1  sticky protocol error flag

Behaviour:
- Reset: arvalid, awvalid, wvalid, cpl_valid and err_unexpected are 0. Outstanding counters are 0 and the write-ID FIFO is empty. Address/data outputs are 0. A mid-operation reset discards all in-flight state.
- cmd_ready is registered-state-only and does not depend on cmd_*. It is 1 when all of the following hold: arvalid=0, awvalid=0, wvalid=0, rd_cnt<MAX_RD_OUT, wr_cnt<MAX_WR_OUT.
- Read accept: next cycle arvalid=1 with araddr/arid held stable until arready. rd_cnt increments on accept.
- Write accept: next cycle awvalid=1 and wvalid=1. Each drops independently on its own handshake, so AW before W, W before AW and both in the same cycle are all legal. cmd_id is pushed into the write-ID FIFO (depth MAX_WR_OUT). wr_cnt increments on accept.
- Max throughput: one command every 2 cycles when the slave is always ready. Accept-to-valid latency is 1 cycle.
- Completion register is a single entry. rready = ~cpl_valid | cpl_ready.
- bready = (~cpl_valid | cpl_ready) & ~rvalid, so R has priority when R and B are both pending.
- R handshake: the completion register loads {write=0, id=rid, data=rdata}. rd_cnt decrements.
- B handshake: the completion register loads {write=1, id=write-ID FIFO head (popped), data=0}. wr_cnt decrements.
- cpl_valid stays held until cpl_ready.
- Counter update when accept and retire occur in the same cycle: the count is unchanged.
- A B handshake with wr_cnt=0, or an R handshake with rd_cnt=0, sets err_unexpected. The response is consumed with no completion and no counter underflow.
- R data may arrive in any ID order. Same-ID responses are assumed to arrive in issue order; the completion reports rid as received.

Optional Feature:
- Macro: AXI_LITE_MASTER_RID_CHECK_EN.
- With the macro defined:
  - Per-ID outstanding counters (N_IDS × clog2(MAX_RD_OUT+1) bits) are added; each increments on AR handshake for arid and decrements on R.
  - An R with a zero count for rid sets err_unexpected and is dropped; rd_cnt is unchanged and no completion is produced.
- Without the macro: only the total rd_cnt check applies.

Decomposition:
- Package axi_lite_pkg holds:
  - default width localparams;
  - addr_t, data_t and id_t typedefs;
  - completion struct cpl_t {write, id, data}.
- Sub-module axi_id_fifo: synchronous FIFO, parametrised WIDTH/DEPTH, with full/empty outputs; used for write-ID tags.

Test Plan:
- Single read: cmd read addr=0x10 id=1; slave arready=1, R 3 cycles later rdata=0xA5A5_0001 rid=1 -> one completion {write=0, id=1, data=0xA5A5_0001}; rd_cnt returns to 0.
- Out of order: reads id 0,1,2,3; slave returns rid 3,1,0,2 -> completions in order 3,1,0,2 with matching data; err_unexpected=0.
- Outstanding limit: 5 reads with arready=1 and rvalid held 0 -> cmd_ready=0 after the 4th AR handshake; it rises the cycle after the first R handshake.
- Split write: cmd write addr=0x20 data=0xDEAD_BEEF id=2; wready 4 cycles before awready -> W and AW each handshake once; B gives completion {write=1, id=2, data=0}.
- Simultaneous R and B with cpl_ready=1 -> read completion first; bready is 0 that cycle; write completion next cycle.
- Error: bvalid=1 with no writes outstanding -> err_unexpected=1 sticky, no cpl_valid. With the macro, R with rid=3 while only id 0 is outstanding -> same result.
